ifetch_launch_ctrl: RTL and testbench
=====================================

// Module: ifetch_launch_ctrl
// PURPOSE
//  Instruction-fetch front end, directly downstream of the fetch-start one-shot.
//  On the launch pulse it sequences PCs from RESET_PC and issues req/gnt requests to instruction memory.
//  Fetched words are buffered in a show-ahead FIFO with their PCs; the FIFO feeds decode.
//  Handles branch redirect: stale in-flight responses are dropped. Handles halt/drain, and pulses
//  the one-shot release when idle again.
// PARAMETERS
//  ADDR_WIDTH  32            PC / memory address width
//  DATA_WIDTH  32            instruction word width
//  RESET_PC    32'h0040_0000 PC loaded on each accepted launch
//  FIFO_DEPTH  4             instruction buffer entries (power of 2, >=2)
// PORTS
//  i_clk              in   1    clock, all state on rising edge
//  i_rst              in   1    asynchronous, active-high reset
//  i_launch           in   1    one-shot start pulse; accepted only in IDLE
//  i_halt             in   1    stop fetching, drain, return to IDLE
//  i_hold             in   1    pipeline stall: no NEW request raised while high
//  i_redirect         in   1    branch/jump redirect strobe
//  i_redirect_pc      in   AW   redirect target (word aligned)
//  o_imem_req         out  1    memory request
//  o_imem_addr        out  AW   request address
//  i_imem_gnt         in   1    request accepted (transfer = req & gnt)
//  i_imem_rvalid      in   1    in-order response, >=1 cycle after its gnt
//  i_imem_rdata       in   DW   response data
//  o_instr_valid      out  1    FIFO head valid
//  o_instr            out  DW   FIFO head instruction
//  o_instr_pc         out  AW   FIFO head PC
//  i_instr_ready      in   1    decode accepts head (pop = valid & ready)
//  o_release_one_shot out  1    1-cycle pulse on DRAIN->IDLE, re-arms the one-shot
//  o_busy             out  1    state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; fetch pc=RESET_PC; resp_pc=RESET_PC; counters and FIFO cleared.
//  States: IDLE -(i_launch)-> RUN -(i_halt)-> DRAIN -(inflight==0 & discard==0 & !req)-> IDLE.
//   - On launch: pc=resp_pc=RESET_PC; FIFO cleared.
//   - Launch outside IDLE is ignored.
//   - Halt in IDLE/DRAIN is ignored.
//  Request rule:
//   - New req is raised in RUN when !i_hold and (inflight + fifo_count) < FIFO_DEPTH (credit).
//   - First req comes the cycle after launch.
//   - Once raised, req and addr stay stable until gnt, regardless of hold/halt/redirect.
//   - On gnt: pc += 4; inflight += 1.
//   - Back-to-back grants allowed.
//  Response:
//   - Every rvalid decrements inflight.
//   - If discard > 0: word dropped, discard -= 1.
//   - Else: {resp_pc, rdata} pushed into the FIFO; resp_pc += 4.
//   - Overflow is impossible by the credit rule; push and pop in the same cycle are legal at any level.
//  Redirect (RUN or DRAIN), priority over every same-cycle event:
//   - FIFO cleared, including any same-cycle push.
//   - discard = inflight + gnt_now - rvalid_now.
//   - A held ungranted req is marked stale; its later gnt adds 1 to discard.
//   - pc = resp_pc = i_redirect_pc.
//   - Next new req uses i_redirect_pc.
//   - Redirect in IDLE is ignored.
//  Counters: inflight and discard are $clog2(FIFO_DEPTH)+1 bits wide; neither may wrap.
//   An assertion fires on underflow or on rvalid with inflight==0.
//  pc wraps modulo 2^AW. The low 2 address bits are always 0.
//  Simultaneous launch+halt in IDLE: launch wins; halt is sampled again next cycle.
//  FIFO contents survive DRAIN->IDLE and stay poppable until the next launch.
//  Reset mid-operation: immediate return to reset values.
//   Instruction memory shares i_rst, so no responses arrive after reset.
// STRUCTURE
//  ifetch_pkg:
//   - state enum fetch_state_e {IDLE, RUN, DRAIN}
//   - INSTR_BYTES=4
//   - typedef fetch_entry_t {pc, instr}
//  Sub-module fifo_fwft_sync (DEPTH, WIDTH): show-ahead FIFO with clear, count, full and empty outputs.
//  Top level holds: FSM, pc/resp_pc, inflight/discard counters, stale flag, and request hold logic.
// TESTING
//  1. Launch, gnt always 1, rvalid 1 cycle later, ready=1 -> req at t+1, addrs 0x400000,+4,+8...;
//     first o_instr_valid at t+3 with pc 0x400000.
//  2. ready=0 with FIFO_DEPTH=4 -> exactly 4 grants, then req stays low;
//     one pop -> exactly one further req.
//  3. Redirect to 0x400100 with 2 in flight -> both responses dropped, FIFO empty;
//     next pushed pc = 0x400100.
//  4. Redirect while req held and gnt=0 for 3 cycles -> addr unchanged until gnt; that response discarded.
//  5. Halt with 3 in flight -> no new req; o_release_one_shot pulses 1 cycle after the last rvalid;
//     o_busy=0 afterwards.
//  6. i_rst asserted mid-RUN with FIFO 2 full -> outputs 0 asynchronously;
//     new launch restarts at 0x400000.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_WIDTH = 32;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_fwft_sync.sv
// Show-ahead synchronous FIFO: head is visible whenever not empty; clear beats push.
module fifo_fwft_sync #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ifetch_launch_ctrl.sv
// Fetch front end: launch/run/drain sequencing, credit-limited req/gnt issue,
// in-order response capture into a show-ahead buffer, and redirect squashing.
module ifetch_launch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_launch,
  input  logic                  i_halt,
  input  logic                  i_hold,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  output logic                  o_release_one_shot,
  output logic                  o_busy
);
  localparam int unsigned           CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned           EW         = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, hold_addr_q, req_addr;
  logic [CW-1:0]         inflight_q, inflight_d, discard_q, discard_d, fifo_count;
  logic                  held_q, stale_q, stale_d;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic                  launch, redirect, credit, new_req, req, gnt;
  logic                  drop, push, pop, clr;

  assign credit   = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign launch   = i_launch & (state_q == IDLE);
  assign redirect = i_redirect & (state_q != IDLE);
  assign new_req  = (state_q == RUN) & ~i_hold & ~held_q & credit;
  assign req      = held_q | new_req;
  assign req_addr = held_q ? hold_addr_q : pc_q;
  assign gnt      = req & i_imem_gnt;
  assign drop     = i_imem_rvalid & (discard_q != '0);
  assign push     = i_imem_rvalid & ~drop;
  assign pop      = ~fifo_empty & i_instr_ready;
  assign clr      = redirect | launch;

  assign o_imem_req         = req;
  assign o_imem_addr        = req ? req_addr : '0;
  assign o_instr_valid      = ~fifo_empty;
  assign o_instr_pc         = fifo_empty ? '0 : fifo_head[EW-1 -: ADDR_WIDTH];
  assign o_instr            = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign o_busy             = (state_q != IDLE);
  assign o_release_one_shot = (state_q == DRAIN) & (inflight_q == '0) & (discard_q == '0) & ~req;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(gnt) - CW'(i_imem_rvalid);
    discard_d  = discard_q + CW'(gnt & stale_q) - CW'(drop);
    stale_d    = stale_q & ~gnt;
    // A stale grant belongs to the abandoned stream, so it must not advance the new pc.
    if (gnt & ~stale_q) pc_d = pc_q + STEP;
    if (push) resp_pc_d = resp_pc_q + STEP;
    if (redirect) begin
      discard_d = inflight_d;
      stale_d   = req & ~i_imem_gnt;
      pc_d      = i_redirect_pc & ALIGN_MASK;
      resp_pc_d = i_redirect_pc & ALIGN_MASK;
    end
    unique case (state_q)
      IDLE: begin
        if (i_launch) begin
          state_d   = RUN;
          pc_d      = RESET_PC & ALIGN_MASK;
          resp_pc_d = RESET_PC & ALIGN_MASK;
        end
      end
      RUN:     if (i_halt) state_d = DRAIN;
      DRAIN:   if (o_release_one_shot) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC & ALIGN_MASK;
      resp_pc_q   <= RESET_PC & ALIGN_MASK;
      inflight_q  <= '0;
      discard_q   <= '0;
      stale_q     <= 1'b0;
      held_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      resp_pc_q   <= resp_pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      stale_q     <= stale_d;
      held_q      <= req & ~i_imem_gnt;
      hold_addr_q <= req_addr;
    end
  end

  fifo_fwft_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (clr),
    .push      (push),
    .push_data ({resp_pc_q, i_imem_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_rvalid_needs_inflight : assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (inflight_q != '0));
  a_inflight_no_wrap : assert property (@(posedge i_clk) disable iff (i_rst)
    !(gnt && !i_imem_rvalid && inflight_q == CW'(FIFO_DEPTH)));
  a_discard_bounded : assert property (@(posedge i_clk) disable iff (i_rst)
    discard_q <= inflight_q);
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && !clr && fifo_full && !pop));

endmodule

// File: tb/tb_ifetch_launch_ctrl.sv
// Randomized bench for ifetch_launch_ctrl against a queue-based stream model.
module tb_ifetch_launch_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        i_rst, i_launch, i_halt, i_hold, i_redirect, i_imem_gnt, i_imem_rvalid;
  logic        i_instr_ready;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_req, o_instr_valid, o_release_one_shot, o_busy;
  logic [31:0] o_imem_addr, o_instr, o_instr_pc;

  always #5 clk = ~clk;

  ifetch_launch_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_launch           (i_launch),
    .i_halt             (i_halt),
    .i_hold             (i_hold),
    .i_redirect         (i_redirect),
    .i_redirect_pc      (i_redirect_pc),
    .o_imem_req         (o_imem_req),
    .o_imem_addr        (o_imem_addr),
    .i_imem_gnt         (i_imem_gnt),
    .i_imem_rvalid      (i_imem_rvalid),
    .i_imem_rdata       (i_imem_rdata),
    .o_instr_valid      (o_instr_valid),
    .o_instr            (o_instr),
    .o_instr_pc         (o_instr_pc),
    .i_instr_ready      (i_instr_ready),
    .o_release_one_shot (o_release_one_shot),
    .o_busy             (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_prob = 100;
  int rv_prob = 100;

  // Model: 0 idle, 1 run, 2 drain; m_fly holds a stale flag per granted request.
  int          m_state;
  logic [31:0] m_pc, m_resp_pc, m_held_addr;
  bit          m_held, m_held_stale;
  bit          m_fly[$];
  logic [63:0] m_fifo[$];
  logic [31:0] mem_addr[$];
  int          mem_cyc[$];

  logic        obs_req, obs_valid, obs_rel, obs_busy;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc = RPC;
    m_resp_pc = RPC;
    m_held = 1'b0;
    m_held_stale = 1'b0;
    m_held_addr = '0;
    m_fly.delete();
    m_fifo.delete();
    mem_addr.delete();
    mem_cyc.delete();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_launch = 0; i_halt = 0; i_hold = 0; i_redirect = 0; i_redirect_pc = '0;
    i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0; i_instr_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    i_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive memory side, compare DUT against the model mid-cycle, advance the model.
  task automatic tick();
    bit          e_req, e_valid, e_rel, e_busy, gx, pushv, new_held, s;
    logic [31:0] e_addr;
    logic [63:0] pe;
    i_imem_gnt = ($urandom_range(99) < gnt_prob);
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    if (mem_addr.size() > 0 && mem_cyc[0] < cyc && $urandom_range(99) < rv_prob) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata = mem_word(mem_addr[0]);
    end
    e_req = m_held || (m_state == 1 && !i_hold && (m_fly.size() + m_fifo.size() < DEPTH));
    e_addr = m_held ? m_held_addr : m_pc;
    e_valid = (m_fifo.size() != 0);
    e_busy = (m_state != 0);
    e_rel = (m_state == 2) && (m_fly.size() == 0) && !e_req;
    @(negedge clk);
    obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_instr_valid;
    obs_pc = o_instr_pc; obs_instr = o_instr; obs_rel = o_release_one_shot; obs_busy = o_busy;
    checks++;
    if (obs_req !== e_req) begin
      errors++; $display("FAIL imem_req cyc %0d: got %b exp %b", cyc, obs_req, e_req);
    end
    if (e_req) begin
      checks++;
      if (obs_addr !== e_addr) begin
        errors++; $display("FAIL imem_addr cyc %0d: got %h exp %h", cyc, obs_addr, e_addr);
      end
    end
    checks++;
    if (obs_valid !== e_valid) begin
      errors++; $display("FAIL instr_valid cyc %0d: got %b exp %b", cyc, obs_valid, e_valid);
    end
    if (e_valid) begin
      checks++;
      if ({obs_pc, obs_instr} !== m_fifo[0]) begin
        errors++;
        $display("FAIL instr_head cyc %0d: got %h/%h exp %h", cyc, obs_pc, obs_instr, m_fifo[0]);
      end
    end
    checks++;
    if (obs_busy !== e_busy || obs_rel !== e_rel) begin
      errors++;
      $display("FAIL busy_release cyc %0d: got %b%b exp %b%b", cyc, obs_busy, obs_rel,
               e_busy, e_rel);
    end
    gx = e_req && i_imem_gnt;
    pushv = 1'b0;
    pe = '0;
    if (i_imem_rvalid) begin
      s = m_fly.pop_front();
      void'(mem_addr.pop_front());
      void'(mem_cyc.pop_front());
      if (!s) begin
        pe = {m_resp_pc, i_imem_rdata};
        pushv = 1'b1;
        m_resp_pc += 32'd4;
      end
    end
    if (gx) begin
      m_fly.push_back(m_held ? m_held_stale : 1'b0);
      mem_addr.push_back(e_addr);
      mem_cyc.push_back(cyc);
      if (!(m_held && m_held_stale)) m_pc += 32'd4;
    end
    new_held = e_req && !i_imem_gnt;
    if (new_held && !m_held) begin
      m_held_addr = e_addr;
      m_held_stale = 1'b0;
    end
    m_held = new_held;
    if (e_valid && i_instr_ready) void'(m_fifo.pop_front());
    if (pushv) m_fifo.push_back(pe);
    if (i_redirect && m_state != 0) begin
      m_fifo.delete();
      foreach (m_fly[i]) m_fly[i] = 1'b1;
      if (new_held) m_held_stale = 1'b1;
      m_pc = i_redirect_pc & 32'hFFFF_FFFC;
      m_resp_pc = i_redirect_pc & 32'hFFFF_FFFC;
    end
    case (m_state)
      0: if (i_launch) begin
        m_state = 1; m_pc = RPC; m_resp_pc = RPC; m_fifo.delete();
      end
      1: if (i_halt) m_state = 2;
      default: if (e_rel) m_state = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    i_launch = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (obs_req !== 1'b0 || obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_rel !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got req%b busy%b valid%b rel%b exp all 0",
                 obs_req, obs_busy, obs_valid, obs_rel);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_prob = 100; rv_prob = 100; i_instr_ready = 1'b1;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    tick();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== RPC) begin
      errors++; $display("FAIL first_req: got %b/%h exp 1/%h", obs_req, obs_addr, RPC);
    end
    tick();
    checks++;
    if (obs_addr !== RPC + 32'd4 || obs_valid !== 1'b0) begin
      errors++; $display("FAIL second_req: got %h/v%b exp %h/v0", obs_addr, obs_valid, RPC + 4);
    end
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== RPC || obs_instr !== mem_word(RPC)) begin
      errors++;
      $display("FAIL first_instr: got v%b %h/%h exp v1 %h/%h", obs_valid, obs_pc, obs_instr,
               RPC, mem_word(RPC));
    end
    repeat (20) tick();
  endtask

  task automatic test_credit();
    int n;
    do_reset();
    gnt_prob = 100; rv_prob = 100; i_instr_ready = 1'b0;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    n = 0;
    repeat (12) begin tick(); if (obs_req && i_imem_gnt) n++; end
    checks++;
    if (n != 4) begin errors++; $display("FAIL credit_fill: got %0d grants exp 4", n); end
    i_instr_ready = 1'b1; tick(); i_instr_ready = 1'b0;
    n = 0;
    repeat (8) begin tick(); if (obs_req && i_imem_gnt) n++; end
    checks++;
    if (n != 1) begin errors++; $display("FAIL credit_refill: got %0d grants exp 1", n); end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    gnt_prob = 100; rv_prob = 0; i_instr_ready = 1'b1;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    tick(); tick();
    i_hold = 1'b1; tick();
    i_redirect = 1'b1; i_redirect_pc = 32'h0040_0100; tick();
    i_redirect = 1'b0; i_hold = 1'b0; rv_prob = 100;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin tick(); found = obs_valid; end
    checks++;
    if (!found || obs_pc !== 32'h0040_0100) begin
      errors++; $display("FAIL redirect_pc: got found%b %h exp 1 00400100", found, obs_pc);
    end
    repeat (6) tick();
  endtask

  task automatic test_held_redirect();
    bit found;
    do_reset();
    gnt_prob = 0; rv_prob = 100; i_instr_ready = 1'b1;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    tick();
    i_redirect = 1'b1; i_redirect_pc = 32'h0040_0200;
    tick();
    i_redirect = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== RPC) begin
        errors++; $display("FAIL held_addr: got %b/%h exp 1/%h", obs_req, obs_addr, RPC);
      end
    end
    gnt_prob = 100;
    tick();
    tick();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0040_0200) begin
      errors++; $display("FAIL post_stale_req: got %b/%h exp 1/00400200", obs_req, obs_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin tick(); found = obs_valid; end
    checks++;
    if (!found || obs_pc !== 32'h0040_0200) begin
      errors++; $display("FAIL stale_dropped: got found%b %h exp 1 00400200", found, obs_pc);
    end
  endtask

  task automatic test_halt_drain();
    int last_rv, rel_k, rel_n, req_n;
    do_reset();
    gnt_prob = 100; rv_prob = 0; i_instr_ready = 1'b1;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    repeat (3) tick();
    i_hold = 1'b1; i_halt = 1'b1; tick();
    i_hold = 1'b0; i_halt = 1'b0; rv_prob = 100;
    last_rv = -1; rel_k = -1; rel_n = 0; req_n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (i_imem_rvalid) last_rv = k;
      if (obs_rel) begin rel_k = k; rel_n++; end
      if (obs_req) req_n++;
    end
    checks++;
    if (rel_n != 1 || rel_k != last_rv + 1 || last_rv != 2) begin
      errors++;
      $display("FAIL release_pulse: got n%0d at %0d last_rv %0d exp n1 at 3 last_rv 2",
               rel_n, rel_k, last_rv);
    end
    checks++;
    if (req_n != 0 || obs_busy !== 1'b0) begin
      errors++; $display("FAIL drain_idle: got req%0d busy%b exp 0 0", req_n, obs_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    gnt_prob = 100; rv_prob = 100; i_instr_ready = 1'b0;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    for (int k = 0; k < 10 && m_fifo.size() < 2; k++) tick();
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_imem_req, o_instr_valid, o_busy, o_release_one_shot} !== 4'b0 ||
        o_imem_addr !== '0 || o_instr !== '0 || o_instr_pc !== '0) begin
      errors++;
      $display("FAIL async_reset: got req%b v%b busy%b rel%b %h %h %h exp all 0",
               o_imem_req, o_instr_valid, o_busy, o_release_one_shot, o_imem_addr, o_instr,
               o_instr_pc);
    end
    do_reset();
    gnt_prob = 100; i_instr_ready = 1'b1;
    i_launch = 1'b1; tick(); i_launch = 1'b0;
    tick();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== RPC) begin
      errors++; $display("FAIL relaunch: got %b/%h exp 1/%h", obs_req, obs_addr, RPC);
    end
  endtask

  task automatic test_random();
    bit idle;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) begin
        gnt_prob = $urandom_range(30, 100);
        rv_prob = $urandom_range(20, 100);
      end
      i_launch = ($urandom_range(19) == 0);
      i_halt = ($urandom_range(59) == 0);
      i_hold = ($urandom_range(3) == 0);
      i_instr_ready = ($urandom_range(2) != 0);
      i_redirect = ($urandom_range(14) == 0);
      i_redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : $urandom();
      tick();
    end
    i_launch = 0; i_redirect = 0; i_hold = 0; i_instr_ready = 1'b1;
    gnt_prob = 100; rv_prob = 100;
    i_halt = 1'b1; tick(); i_halt = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin tick(); idle = !obs_busy; end
    checks++;
    if (!idle) begin errors++; $display("FAIL random_drain: got busy 1 exp 0"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_credit();
    test_redirect();
    test_held_redirect();
    test_halt_drain();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
